pc_sequencer: RTL and testbench

- Owns the MIPS program-counter register and decides when and where the PC advances.
- Sequences the PC through the run modes: idle, continuous, single-step, halt-drain and done.
- Resolves next-PC priority between branch, jump, stall and sequential increment.
- Sits between the debug/control unit (start, mode, step) and the IF stage; it also drives the global pipeline enable.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/pc_adder.sv | 16 +
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 tb/tb_pc_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS control slice.
// Contents:
//   state_t          - PC sequencer FSM encodings (IDLE..DONE)
//   MODE_CONT/STEP   - run-mode values sampled from i_mode at start
//   RESET_PC_DEFAULT - default PC loaded at reset and on restart
package mips_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_WAIT_STEP = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   localparam logic MODE_CONT = 1'b0;
   localparam logic MODE_STEP = 1'b1;

   localparam int RESET_PC_DEFAULT = 0;

endpackage

// File: rtl/pc_adder.sv
// Combinational PC incrementer.
// Ports:
//   i_pc   - current PC
//   i_cte  - constant added to the PC
//   o_sum  - i_pc + i_cte, wrapping modulo 2^len
module pc_adder #(
   parameter int len = 32
) (
   input  logic [len-1:0] i_pc,
   input  logic [len-1:0] i_cte,
   output logic [len-1:0] o_sum
);

   assign o_sum = i_pc + i_cte;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner and run-mode sequencer.
// Ports:
//   i_clk, i_reset        - clock, synchronous active-high reset
//   i_start, i_mode       - start pulse; mode (0 continuous, 1 single-step)
//   i_step                - single-step advance pulse
//   i_stall               - hold PC (load-use hazard)
//   i_branch_taken/target - taken branch and its destination
//   i_jump/target         - jump and its destination
//   i_halt_detected       - halt instruction in IF/ID
//   o_pc                  - current PC
//   o_pipe_enable         - global pipeline-register enable
//   o_state               - FSM state code
//   o_cycle_count         - enabled cycles since start (saturating)
//   o_done                - high while in DONE
module pc_sequencer
   import mips_pkg::*;
#(
   parameter int             len          = 32,
   parameter logic [len-1:0] RESET_PC     = len'(RESET_PC_DEFAULT),
   parameter int             DRAIN_CYCLES = 4,
   parameter int             cnt_len      = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_mode,
   input  logic               i_step,
   input  logic               i_stall,
   input  logic               i_branch_taken,
   input  logic [len-1:0]     i_branch_target,
   input  logic               i_jump,
   input  logic [len-1:0]     i_jump_target,
   input  logic               i_halt_detected,
   output logic [len-1:0]     o_pc,
   output logic               o_pipe_enable,
   output logic [2:0]         o_state,
   output logic [cnt_len-1:0] o_cycle_count,
   output logic               o_done
);

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

   state_t             state_reg, state_next;
   logic [len-1:0]     pc_reg, pc_next, pc_plus;
   logic [cnt_len-1:0] cycle_reg, cycle_next;
   logic [DW-1:0]      drain_reg, drain_next;
   logic               pipe_enable, done;
   logic               run_state, halt_accept, restart, drain_last;

   pc_adder #(.len(len)) u_pc_adder (
      .i_pc  (pc_reg),
      .i_cte (len'(1)),
      .o_sum (pc_plus)
   );

   assign run_state   = (state_reg == ST_RUN) || (state_reg == ST_WAIT_STEP);
   // A halt beside a taken branch is on the wrong path; beside a stall it
   // is simply retried on the next advancing cycle.
   assign halt_accept = pipe_enable && run_state && i_halt_detected
                        && !i_branch_taken && !i_stall;
   assign restart     = (state_reg == ST_DONE) && i_start;
   assign drain_last  = (drain_reg == DW'(DRAIN_CYCLES - 1));

   // State and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg <= ST_IDLE;
         pc_reg    <= RESET_PC;
         cycle_reg <= '0;
         drain_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         cycle_reg <= cycle_next;
         drain_reg <= drain_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (i_start)
               state_next = (i_mode == MODE_STEP) ? ST_WAIT_STEP : ST_RUN;
         end
         ST_RUN, ST_WAIT_STEP: begin
            if (halt_accept)
               state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_last)
               state_next = ST_DONE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      pipe_enable = 1'b0;
      done        = 1'b0;
      case (state_reg)
         ST_RUN:       pipe_enable = 1'b1;
         ST_WAIT_STEP: pipe_enable = i_step;
         ST_DRAIN:     pipe_enable = 1'b1;
         ST_DONE:      done        = 1'b1;
         default:      pipe_enable = 1'b0;
      endcase
   end

   // Next PC, cycle counter and drain counter
   always_comb begin
      pc_next    = pc_reg;
      cycle_next = cycle_reg;
      drain_next = drain_reg;

      if (restart) begin
         pc_next = RESET_PC;
      end else if (pipe_enable && run_state) begin
         if (i_branch_taken)
            pc_next = i_branch_target;
         else if (halt_accept)
            pc_next = pc_reg;
         else if (i_jump)
            pc_next = i_jump_target;
         else if (i_stall)
            pc_next = pc_reg;
         else
            pc_next = pc_plus;
      end

      if (restart)
         cycle_next = '0;
      else if (pipe_enable && (cycle_reg != '1))
         cycle_next = cycle_reg + cnt_len'(1);

      if (halt_accept)
         drain_next = '0;
      else if (state_reg == ST_DRAIN)
         drain_next = drain_reg + DW'(1);
   end

   assign o_pc          = pc_reg;
   assign o_pipe_enable = pipe_enable;
   assign o_state       = state_reg;
   assign o_cycle_count = cycle_reg;
   assign o_done        = done;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, mode, step, stall, br, jmp, halt;
   logic [31:0] br_tgt, jmp_tgt;
   logic [31:0] pc;
   logic        pe, done;
   logic [2:0]  st;
   logic [31:0] cc;

   logic        w_reset, w_start;
   logic [7:0]  w_pc;
   logic        w_pe, w_done;
   logic [2:0]  w_st;
   logic [31:0] w_cc;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode),
      .i_step(step), .i_stall(stall), .i_branch_taken(br),
      .i_branch_target(br_tgt), .i_jump(jmp), .i_jump_target(jmp_tgt),
      .i_halt_detected(halt), .o_pc(pc), .o_pipe_enable(pe),
      .o_state(st), .o_cycle_count(cc), .o_done(done)
   );

   pc_sequencer #(.len(8), .RESET_PC(8'hFE)) dut_w (
      .i_clk(clk), .i_reset(w_reset), .i_start(w_start), .i_mode(1'b0),
      .i_step(1'b0), .i_stall(1'b0), .i_branch_taken(1'b0),
      .i_branch_target(8'h00), .i_jump(1'b0), .i_jump_target(8'h00),
      .i_halt_detected(1'b0), .o_pc(w_pc), .o_pipe_enable(w_pe),
      .o_state(w_st), .o_cycle_count(w_cc), .o_done(w_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      reset = 0; start = 0; mode = 0; step = 0; stall = 0;
      br = 0; jmp = 0; halt = 0; br_tgt = 0; jmp_tgt = 0;
   endtask

   task automatic do_reset();
      clr();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      clr();
      reset = 1; start = 1;
      tick();
      reset = 0; start = 0;
      n_cmp++; if (pc !== 32'd0) begin n_err++; $display("FAIL reset_pc got %0h want 0", pc); end
      n_cmp++; if (st !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", st); end
      n_cmp++; if (pe !== 1'b0) begin n_err++; $display("FAIL reset_pe got %0b want 0", pe); end
      n_cmp++; if (cc !== 32'd0) begin n_err++; $display("FAIL reset_cc got %0d want 0", cc); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
      $display("reset: pc=%0h state=%0d pe=%0b cc=%0d", pc, st, pe, cc);
   endtask

   task automatic test_continuous();
      do_reset();
      start = 1; mode = 0;
      n_cmp++; if (pe !== 1'b0) begin n_err++; $display("FAIL idle_pe got %0b want 0", pe); end
      tick();
      start = 0;
      n_cmp++; if (st !== 3'd1 || pe !== 1'b1) begin n_err++; $display("FAIL cont_start state/pe got %0d/%0b want 1/1", st, pe); end
      for (int i = 1; i <= 5; i++) begin
         tick();
         n_cmp++; if (pc !== 32'(i)) begin n_err++; $display("FAIL cont_pc got %0h want %0h", pc, i); end
         $display("continuous: pc=%0h cc=%0d", pc, cc);
      end
      n_cmp++; if (cc !== 32'd5) begin n_err++; $display("FAIL cont_cc got %0d want 5", cc); end
   endtask

   task automatic test_stall_branch();
      do_reset();
      start = 1; tick(); start = 0;
      tick(); tick(); tick();
      n_cmp++; if (pc !== 32'd3) begin n_err++; $display("FAIL sb_pre got %0h want 3", pc); end
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++; if (pc !== 32'd3) begin n_err++; $display("FAIL sb_stall got %0h want 3", pc); end
         $display("stall: pc=%0h", pc);
      end
      stall = 0; jmp = 1; jmp_tgt = 32'h40; br = 1; br_tgt = 32'h80;
      tick();
      n_cmp++; if (pc !== 32'h80) begin n_err++; $display("FAIL sb_branch_wins got %0h want 80", pc); end
      jmp = 0; br = 0;
      tick();
      n_cmp++; if (pc !== 32'h81) begin n_err++; $display("FAIL sb_after got %0h want 81", pc); end
      jmp = 1; jmp_tgt = 32'h40;
      tick();
      jmp = 0;
      n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL sb_jump got %0h want 40", pc); end
      n_cmp++; if (cc !== 32'd8) begin n_err++; $display("FAIL sb_cc got %0d want 8", cc); end
      $display("branch/jump: pc=%0h cc=%0d", pc, cc);
   endtask

   task automatic test_step();
      do_reset();
      start = 1; mode = 1; tick(); start = 0; mode = 0;
      n_cmp++; if (st !== 3'd2) begin n_err++; $display("FAIL step_state got %0d want 2", st); end
      for (int c = 0; c < 10; c++) begin
         step = (c == 2 || c == 7);
         #1;
         n_cmp++; if (pe !== step) begin n_err++; $display("FAIL step_pe cycle %0d got %0b want %0b", c, pe, step); end
         tick();
      end
      step = 0;
      n_cmp++; if (pc !== 32'd2) begin n_err++; $display("FAIL step_pc got %0h want 2", pc); end
      n_cmp++; if (cc !== 32'd2) begin n_err++; $display("FAIL step_cc got %0d want 2", cc); end
      $display("single-step: pc=%0h cc=%0d", pc, cc);
   endtask

   task automatic test_halt();
      do_reset();
      start = 1; tick(); start = 0;
      tick(); tick(); tick(); tick();
      halt = 1; br = 1; br_tgt = 32'd6;
      tick();
      br = 0;
      n_cmp++; if (pc !== 32'd6 || st !== 3'd1) begin n_err++; $display("FAIL halt_wrongpath pc/state got %0h/%0d want 6/1", pc, st); end
      stall = 1;
      tick();
      stall = 0;
      n_cmp++; if (pc !== 32'd6 || st !== 3'd1) begin n_err++; $display("FAIL halt_stall pc/state got %0h/%0d want 6/1", pc, st); end
      tick();
      halt = 0;
      n_cmp++; if (pc !== 32'd6 || st !== 3'd3) begin n_err++; $display("FAIL halt_accept pc/state got %0h/%0d want 6/3", pc, st); end
      br = 1; br_tgt = 32'h99;
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (pe !== 1'b1 || st !== 3'd3) begin n_err++; $display("FAIL drain_%0d pe/state got %0b/%0d want 1/3", k, pe, st); end
         tick();
         n_cmp++; if (pc !== 32'd6) begin n_err++; $display("FAIL drain_pc got %0h want 6", pc); end
      end
      br = 0;
      n_cmp++; if (st !== 3'd4 || done !== 1'b1 || pe !== 1'b0) begin n_err++; $display("FAIL done state/done/pe got %0d/%0b/%0b want 4/1/0", st, done, pe); end
      n_cmp++; if (cc !== 32'd11) begin n_err++; $display("FAIL halt_cc got %0d want 11", cc); end
      tick();
      n_cmp++; if (cc !== 32'd11 || pc !== 32'd6) begin n_err++; $display("FAIL done_frozen cc/pc got %0d/%0h want 11/6", cc, pc); end
      $display("halt: state=%0d done=%0b pc=%0h cc=%0d", st, done, pc, cc);
   endtask

   task automatic test_restart();
      start = 1; mode = 0;
      tick();
      start = 0;
      n_cmp++; if (pc !== 32'd0 || cc !== 32'd0 || st !== 3'd1) begin n_err++; $display("FAIL restart pc/cc/state got %0h/%0d/%0d want 0/0/1", pc, cc, st); end
      tick();
      n_cmp++; if (pc !== 32'd1) begin n_err++; $display("FAIL restart_pc1 got %0h want 1", pc); end
      start = 1; mode = 1;
      tick();
      start = 0; mode = 0;
      n_cmp++; if (st !== 3'd1 || pc !== 32'd2) begin n_err++; $display("FAIL start_in_run state/pc got %0d/%0h want 1/2", st, pc); end
      $display("restart: pc=%0h state=%0d cc=%0d", pc, st, cc);
   endtask

   task automatic test_reset_mid_drain();
      halt = 1; tick(); halt = 0;
      tick(); tick();
      n_cmp++; if (st !== 3'd3) begin n_err++; $display("FAIL mid_drain_pre got %0d want 3", st); end
      reset = 1; start = 1;
      tick();
      reset = 0; start = 0;
      n_cmp++; if (st !== 3'd0 || pc !== 32'd0 || cc !== 32'd0 || pe !== 1'b0) begin n_err++; $display("FAIL mid_drain_reset state/pc/cc/pe got %0d/%0h/%0d/%0b want 0/0/0/0", st, pc, cc, pe); end
      $display("reset mid-drain: state=%0d pc=%0h cc=%0d", st, pc, cc);
   endtask

   task automatic test_wrap();
      w_reset = 1; w_start = 0;
      tick();
      w_reset = 0; w_start = 1;
      n_cmp++; if (w_pc !== 8'hFE) begin n_err++; $display("FAIL wrap_reset got %0h want fe", w_pc); end
      tick();
      w_start = 0;
      tick();
      n_cmp++; if (w_pc !== 8'hFF) begin n_err++; $display("FAIL wrap_ff got %0h want ff", w_pc); end
      tick();
      n_cmp++; if (w_pc !== 8'h00) begin n_err++; $display("FAIL wrap_00 got %0h want 00", w_pc); end
      $display("wrap: pc=%0h", w_pc);
   endtask

   initial begin
      clr();
      w_reset = 1; w_start = 0;
      test_reset();
      test_continuous();
      test_stall_branch();
      test_step();
      test_halt();
      test_restart();
      test_reset_mid_drain();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
